// File: rtl/arb_req_fifo.sv
// Three independent per-channel request FIFOs feeding a round-robin arbiter; one-hot grant pops one entry.
// Optional sticky protocol-error output enabled by defining ARB_REQ_FIFO_ERR_EN.
module arb_req_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [2:0]      in_vld,
    input  logic [3*DW-1:0] in_data,
    output logic [2:0]      in_rdy,
    output logic [2:0]      req_vld,
    input  logic [2:0]      grant,
    output logic            out_vld,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_id
`ifdef ARB_REQ_FIFO_ERR_EN
    ,
    output logic            err
`endif
);

    localparam int unsigned NCH = 3;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    logic [NCH-1:0] full_c;
    logic [NCH-1:0] wr_en_c;
    logic [NCH-1:0] rd_en_c;
    logic [DW-1:0]  head_c [NCH];
    logic           grant_onehot_c;

    assign grant_onehot_c = (grant == 3'b001) || (grant == 3'b010) || (grant == 3'b100);

    for (genvar g = 0; g < NCH; g++) begin : gen_ch
        logic [PW-1:0] wr_ptr_q, wr_ptr_d;
        logic [PW-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [DW-1:0] mem_q [DEPTH];

        assign full_c[g]  = (cnt_q == CW'(DEPTH));
        assign in_rdy[g]  = ~full_c[g];
        assign req_vld[g] = (cnt_q != '0);
        assign wr_en_c[g] = in_vld[g] & ~full_c[g];
        // An empty channel never pops, which also covers write+grant on empty.
        assign rd_en_c[g] = grant_onehot_c & grant[g] & req_vld[g];
        assign head_c[g]  = mem_q[rd_ptr_q];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (wr_en_c[g]) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_en_c[g]) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({wr_en_c[g], rd_en_c[g]})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage needs no reset: pointers and counts define what is valid.
        always_ff @(posedge clk) begin
            if (wr_en_c[g]) begin
                mem_q[wr_ptr_q] <= in_data[g*DW +: DW];
            end
        end
    end

    logic          out_vld_q, out_vld_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_id_q, out_id_d;

    always_comb begin
        out_vld_d  = 1'b0;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        for (int i = 0; i < NCH; i++) begin
            if (rd_en_c[i]) begin
                out_vld_d  = 1'b1;
                out_data_d = head_c[i];
                out_id_d   = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_id   = out_id_q;

`ifdef ARB_REQ_FIFO_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((grant != 3'b000) && !grant_onehot_c) begin
            err_d = 1'b1;
        end
        if (grant_onehot_c && ((grant & ~req_vld) != 3'b000)) begin
            err_d = 1'b1;
        end
        if ((in_vld & full_c) != 3'b000) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_arb_req_fifo.sv
// Randomised scoreboard bench for arb_req_fifo: queue-based reference model, decoupled output monitor.
module tb_arb_req_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NCH   = 3;

    logic            clk;
    logic            rstn;
    logic [2:0]      in_vld;
    logic [3*DW-1:0] in_data;
    logic [2:0]      in_rdy;
    logic [2:0]      req_vld;
    logic [2:0]      grant;
    logic            out_vld;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;
`ifdef ARB_REQ_FIFO_ERR_EN
    logic            err;
`endif

    arb_req_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .req_vld  (req_vld),
        .grant    (grant),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_id   (out_id)
`ifdef ARB_REQ_FIFO_ERR_EN
        ,
        .err      (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    // Reference state: contents of each channel queue after the next rising edge.
    logic [DW-1:0] mq [NCH][$];
    exp_t          sb[$];
    logic [2:0]    exp_rdy;
    logic [2:0]    exp_req;
    logic [DW-1:0] last_data;
    logic [1:0]    last_id;
    logic          exp_err;

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge and advance the model to the next rising edge.
    task automatic step(input logic [2:0] vld, input logic [3*DW-1:0] data,
                        input logic [2:0] gnt, input logic rst_n);
        logic       onehot;
        logic [2:0] pop;
        logic [2:0] wr;
        exp_t       e;
        @(negedge clk);
        rstn    = rst_n;
        in_vld  = vld;
        in_data = data;
        grant   = gnt;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) mq[i].delete();
            sb.delete();
            last_data = '0;
            last_id   = '0;
            exp_err   = 1'b0;
        end else begin
            onehot = (gnt == 3'b001) || (gnt == 3'b010) || (gnt == 3'b100);
            if (gnt != 3'b000 && !onehot) exp_err = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                pop[i] = onehot && gnt[i] && (mq[i].size() > 0);
                wr[i]  = vld[i] && (mq[i].size() < DEPTH);
                if (onehot && gnt[i] && mq[i].size() == 0) exp_err = 1'b1;
                if (vld[i] && mq[i].size() == DEPTH) exp_err = 1'b1;
            end
            for (int i = 0; i < NCH; i++) begin
                if (pop[i]) begin
                    e.id   = 2'(i);
                    e.data = mq[i].pop_front();
                    sb.push_back(e);
                    last_data = e.data;
                    last_id   = e.id;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (wr[i]) mq[i].push_back(data[i*DW +: DW]);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            exp_rdy[i] = (mq[i].size() < DEPTH);
            exp_req[i] = (mq[i].size() != 0);
        end
    endtask

    // Monitor: samples just after each rising edge, independent of the stimulus thread.
    logic mon_en;
    initial begin : monitor
        exp_t e;
        logic ev;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                check("in_rdy", 32'(in_rdy), 32'(exp_rdy));
                check("req_vld", 32'(req_vld), 32'(exp_req));
                ev = (sb.size() != 0);
                check("out_vld", 32'(out_vld), 32'(ev));
                if (ev) begin
                    e = sb.pop_front();
                    if (out_vld === 1'b1) begin
                        check("out_id", 32'(out_id), 32'(e.id));
                        check("out_data", 32'(out_data), 32'(e.data));
                    end
                end else begin
                    check("out_id_hold", 32'(out_id), 32'(last_id));
                    check("out_data_hold", 32'(out_data), 32'(last_data));
                end
`ifdef ARB_REQ_FIFO_ERR_EN
                check("err", 32'(err), 32'(exp_err));
`endif
            end
        end
    end

    function automatic logic [2:0] rand_grant();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7) return 3'(3'b001 << $urandom_range(0, 2));
        if (r == 7) return 3'b000;
        return 3'($urandom);
    endfunction

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mon_en    = 1'b1;
        rstn      = 1'b0;
        in_vld    = '0;
        in_data   = '0;
        grant     = '0;
        exp_rdy   = 3'b111;
        exp_req   = 3'b000;
        last_data = '0;
        last_id   = '0;
        exp_err   = 1'b0;

        // Reset held for three cycles.
        repeat (3) step(3'b000, '0, 3'b000, 1'b0);

        // Fill channel 0, then a fifth write that must be dropped.
        step(3'b001, 24'h000011, 3'b000, 1'b1);
        step(3'b001, 24'h000022, 3'b000, 1'b1);
        step(3'b001, 24'h000033, 3'b000, 1'b1);
        step(3'b001, 24'h000044, 3'b000, 1'b1);
        step(3'b001, 24'h000055, 3'b000, 1'b1);

        // Drain in order, one grant per cycle.
        repeat (4) step(3'b000, '0, 3'b001, 1'b1);
        step(3'b000, '0, 3'b000, 1'b1);

        // One entry per channel, served 0,1,2.
        step(3'b111, 24'hC2B1A0, 3'b000, 1'b1);
        step(3'b000, '0, 3'b001, 1'b1);
        step(3'b000, '0, 3'b010, 1'b1);
        step(3'b000, '0, 3'b100, 1'b1);
        step(3'b000, '0, 3'b000, 1'b1);

        // Channel 1 at count 2 with write+grant; then write+grant on empty channel 2.
        step(3'b010, 24'h006100, 3'b000, 1'b1);
        step(3'b010, 24'h006200, 3'b000, 1'b1);
        step(3'b010, 24'h006300, 3'b010, 1'b1);
        step(3'b100, 24'h700000, 3'b100, 1'b1);
        step(3'b000, '0, 3'b000, 1'b1);

        // Non-one-hot grant with channels 0 and 1 non-empty.
        step(3'b001, 24'h000080, 3'b000, 1'b1);
        step(3'b000, '0, 3'b011, 1'b1);
        step(3'b000, '0, 3'b000, 1'b1);

        // Reset mid-operation discards queued entries.
        step(3'b000, '0, 3'b000, 1'b0);
        step(3'b000, '0, 3'b000, 1'b1);
        step(3'b000, '0, 3'b001, 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step(3'($urandom), 24'($urandom), rand_grant(), ($urandom_range(0, 299) != 0));
        end

        repeat (3) step(3'b000, '0, 3'b000, 1'b1);
        @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arb_req_fifo.md
ARB_REQ_FIFO -- requirements
Module: arb_req_fifo

Interface
REQ-001 SHALL have parameter DW, default 8, payload width per channel.
REQ-002 SHALL have parameter DEPTH, default 4, entries per channel queue; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rstn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_vld, input, 3, per-channel write valid from the requesters.
REQ-006 SHALL have port in_data, input, 3*DW, channel i payload at bits [i*DW +: DW].
REQ-007 SHALL have port in_rdy, output, 3, per-channel write ready.
REQ-008 SHALL have port req_vld, output, 3, per-channel request to the downstream round-robin arbiter.
REQ-009 SHALL have port grant, input, 3, one-hot grant returned by the arbiter.
REQ-010 SHALL have port out_vld, output, 1, popped-entry valid.
REQ-011 SHALL have port out_data, output, DW, popped payload.
REQ-012 SHALL have port out_id, output, 2, index of the popped channel (0..2).

Function
REQ-013 SHALL hold one independent FIFO per channel, each with a write pointer, a read pointer and an occupancy count in the range 0..DEPTH.
REQ-014 SHALL set in_rdy[i] = (count[i] < DEPTH), derived from registered state only; in_vld SHALL NOT feed in_rdy combinationally.
REQ-015 SHALL write in_data channel i on a cycle where in_vld[i] && in_rdy[i] is true; a write when full SHALL be dropped with no state change.
REQ-016 SHALL set req_vld[i] = (count[i] != 0), from registered state; a write to an empty queue SHALL raise req_vld[i] on the following cycle.
REQ-017 SHALL pop channel i when grant == one-hot(i) and count[i] != 0.
REQ-018 SHALL ignore a grant of zero or a non-one-hot grant: no pop takes place.
REQ-019 SHALL register out_vld, out_data and out_id on the cycle after a pop (latency 1); out_vld SHALL be 0 on cycles after a non-pop, and out_data/out_id SHALL keep their last value.
REQ-020 SHALL, on a simultaneous write and pop to the same channel when count is between 1 and DEPTH-1, leave count unchanged and perform both operations.
REQ-021 SHALL, when full, not accept a write in the same cycle as a pop, because in_rdy is already 0; no bypass.
REQ-022 SHALL, on a simultaneous write and grant to an empty channel, write only; the pop is suppressed.
REQ-023 SHALL wrap pointers modulo DEPTH and preserve per-channel FIFO order.

Reset
REQ-024 SHALL, on the clk edge with rstn=0, clear all counts and pointers, and set out_vld=0, out_data=0 and out_id=0; in_rdy SHALL then read 3'b111 and req_vld SHALL read 3'b000.
REQ-025 SHALL discard all queued entries when reset is asserted mid-operation; FIFO storage SHALL not require a reset.

Configuration
REQ-026 SHALL, with macro ARB_REQ_FIFO_ERR_EN defined, add output err (1 bit); err is sticky, cleared only by reset, and set the cycle after any of: a non-one-hot nonzero grant, a grant to an empty channel, or a write attempt while full.
REQ-027 SHALL, without ARB_REQ_FIFO_ERR_EN, omit the err port and its logic; all other behaviour is unchanged.

Verification
REQ-028 SHALL be verified for reset: rstn=0 for 3 cycles -> in_rdy=3'b111, req_vld=3'b000, out_vld=0.
REQ-029 SHALL be verified for fill/full: write 0x11,0x22,0x33,0x44 to channel 0 with no grant -> in_rdy[0]=0 after the 4th write; a 5th write of 0x55 is dropped (err=1 if enabled).
REQ-030 SHALL be verified for order/latency: from the previous scenario, grant=3'b001 for 4 cycles -> out_vld=1, out_id=0, out_data=0x11,0x22,0x33,0x44 on consecutive cycles, each one cycle after its grant; req_vld[0] falls after the last pop.
REQ-031 SHALL be verified for round-robin interplay: channels 0,1,2 each hold one entry (0xA0,0xB1,0xC2), grants 001,010,100 -> out_id sequence 0,1,2 with the matching data; req_vld is 3'b000 afterwards.
REQ-032 SHALL be verified for simultaneous operations: channel 1 at count 2 with write and grant in the same cycle -> count stays 2 and the oldest entry is output; on an empty channel 2, write+grant -> out_vld=0 the next cycle and req_vld[2]=1.
REQ-033 SHALL be verified for a bad grant: grant=3'b011 with both channels non-empty -> no pop, out_vld=0, counts unchanged (err=1 if enabled).
